// File: rtl/pong_pkg.sv
// Shared encodings for the pong match controller.
// State and winner codes are visible on debug/status ports.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_PAUSED     = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    localparam logic DIR_P1 = 1'b0;
    localparam logic DIR_P2 = 1'b1;

endpackage

// File: rtl/pong_serve_timer.sv
// Serve delay countdown: load restarts it, done pulses once
// on the last cycle of the delay window.
module pong_serve_timer #(
    parameter int unsigned DELAY_CLKS = 25000000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Load,
    output logic o_Done
);

    localparam int unsigned CW = $clog2(DELAY_CLKS + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(DELAY_CLKS);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_Load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Done = !i_Load && (cnt_q == ONE);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencing: serve delay, scoring, pause and win detection.
// Every output is a register; next values are computed from state_d.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE        = 9,
    parameter int unsigned SERVE_DELAY_CLKS = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_P1_Point,
    input  logic       i_P2_Point,
    input  logic       i_Pause,
    output logic       o_Ball_Enable,
    output logic       o_Ball_Reset,
    output logic       o_Serve_Dir,
    output logic [3:0] o_P1_Score,
    output logic [3:0] o_P2_Score,
    output logic [1:0] o_Winner,
    output logic [2:0] o_State
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_e     state_q, state_d;
    winner_e    win_q, win_d;
    logic [3:0] p1_q, p1_d;
    logic [3:0] p2_q, p2_d;
    logic       dir_q, dir_d;
    logic       en_q, en_d;
    logic       brst_q, brst_d;
    logic       load;
    logic       done;
    logic       p1_hit, p2_hit;
    logic [3:0] p1_inc, p2_inc;

    pong_serve_timer #(
        .DELAY_CLKS(SERVE_DELAY_CLKS)
    ) u_timer (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Load (load),
        .o_Done (done)
    );

    // A simultaneous pair of point pulses is ambiguous and dropped.
    assign p1_hit = i_P1_Point & ~i_P2_Point;
    assign p2_hit = i_P2_Point & ~i_P1_Point;
    assign p1_inc = p1_q + 4'd1;
    assign p2_inc = p2_q + 4'd1;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        dir_d   = dir_q;
        brst_d  = 1'b0;
        load    = 1'b0;
        if (i_Start) begin
            state_d = ST_SERVE_WAIT;
            win_d   = WIN_NONE;
            p1_d    = '0;
            p2_d    = '0;
            dir_d   = DIR_P1;
            brst_d  = 1'b1;
            load    = 1'b1;
        end else begin
            case (state_q)
                ST_SERVE_WAIT: begin
                    if (done) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (p1_hit) begin
                        p1_d = p1_inc;
                        if (p1_inc == WIN) begin
                            state_d = ST_GAME_OVER;
                            win_d   = WIN_P1;
                        end else begin
                            state_d = ST_SERVE_WAIT;
                            dir_d   = DIR_P2;
                            brst_d  = 1'b1;
                            load    = 1'b1;
                        end
                    end else if (p2_hit) begin
                        p2_d = p2_inc;
                        if (p2_inc == WIN) begin
                            state_d = ST_GAME_OVER;
                            win_d   = WIN_P2;
                        end else begin
                            state_d = ST_SERVE_WAIT;
                            dir_d   = DIR_P1;
                            brst_d  = 1'b1;
                            load    = 1'b1;
                        end
                    end else if (i_Pause) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (i_Pause) state_d = ST_PLAY;
                end
                default: ;
            endcase
        end
        en_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
            win_q   <= WIN_NONE;
            p1_q    <= '0;
            p2_q    <= '0;
            dir_q   <= DIR_P1;
            en_q    <= 1'b0;
            brst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            brst_q  <= brst_d;
        end
    end

    assign o_State       = state_q;
    assign o_Winner      = win_q;
    assign o_P1_Score    = p1_q;
    assign o_P2_Score    = p2_q;
    assign o_Serve_Dir   = dir_q;
    assign o_Ball_Enable = en_q;
    assign o_Ball_Reset  = brst_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match scenarios plus random
// pulse traffic, all checked against a rule-level match model.
module tb_pong_match_ctrl;
    import pong_pkg::*;

    localparam int WS = 3;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       p1 = 1'b0;
    logic       p2 = 1'b0;
    logic       pz = 1'b0;
    logic       en, brst, dir;
    logic [3:0] s1, s2;
    logic [1:0] win;
    logic [2:0] st;

    pong_match_ctrl #(
        .WIN_SCORE(WS),
        .SERVE_DELAY_CLKS(SD)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Start      (start),
        .i_P1_Point   (p1),
        .i_P2_Point   (p2),
        .i_Pause      (pz),
        .o_Ball_Enable(en),
        .o_Ball_Reset (brst),
        .o_Serve_Dir  (dir),
        .o_P1_Score   (s1),
        .o_P2_Score   (s2),
        .o_Winner     (win),
        .o_State      (st)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Match model: what a referee would track.
    state_e m_st;
    int m_p1, m_p2, m_win, m_dir, m_brst, m_wait;

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = ST_IDLE;
        m_p1 = 0; m_p2 = 0; m_win = 0;
        m_dir = 0; m_brst = 0; m_wait = 0;
    endtask

    task automatic model_step(input logic s, input logic a,
                              input logic b, input logic z);
        m_brst = 0;
        if (s) begin
            m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
            m_brst = 1; m_st = ST_SERVE_WAIT; m_wait = SD;
        end else if (m_st == ST_SERVE_WAIT) begin
            if (m_wait == 1) m_st = ST_PLAY;
            else m_wait--;
        end else if (m_st == ST_PLAY) begin
            if (a != b) begin
                if (a) m_p1++; else m_p2++;
                if ((a ? m_p1 : m_p2) == WS) begin
                    m_st = ST_GAME_OVER;
                    m_win = a ? 1 : 2;
                end else begin
                    // Serve goes toward whoever conceded.
                    m_dir = a ? 1 : 0;
                    m_brst = 1;
                    m_st = ST_SERVE_WAIT;
                    m_wait = SD;
                end
            end else if (z) begin
                m_st = ST_PAUSED;
            end
        end else if (m_st == ST_PAUSED) begin
            if (z) m_st = ST_PLAY;
        end
    endtask

    task automatic check_all();
        chk("state", 32'(st), 32'(m_st));
        chk("p1_score", 32'(s1), 32'(m_p1));
        chk("p2_score", 32'(s2), 32'(m_p2));
        chk("winner", 32'(win), 32'(m_win));
        chk("serve_dir", 32'(dir), 32'(m_dir));
        chk("ball_reset", 32'(brst), 32'(m_brst));
        chk("ball_enable", 32'(en), 32'(m_st == ST_PLAY));
    endtask

    task automatic cyc(input logic s, input logic a,
                       input logic b, input logic z);
        @(negedge clk);
        start = s; p1 = a; p2 = b; pz = z;
        @(posedge clk);
        model_step(s, a, b, z);
        #1 check_all();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_serve(input string nm);
        for (int i = 0; i < SD - 1; i++) begin
            idle();
            chk({nm, "_en_low"}, 32'(en), 32'd0);
        end
        idle();
        chk({nm, "_en_high"}, 32'(en), 32'd1);
    endtask

    initial begin
        model_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_scores", 32'({s1, s2}), 32'd0);
        chk("rst_outs", 32'({win, dir, en, brst}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        chk("idle_hold", 32'(st), 32'd0);

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_brst", 32'(brst), 32'd1);
        chk("start_state", 32'(st), 32'd1);
        wait_serve("serve0");
        chk("serve0_brst", 32'(brst), 32'd0);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("p1pt_score", 32'(s1), 32'd1);
        chk("p1pt_dir", 32'(dir), 32'd1);
        chk("p1pt_brst", 32'(brst), 32'd1);
        wait_serve("serve1");

        for (int k = 1; k < WS; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            chk("p2pt_dir", 32'(dir), 32'd0);
            wait_serve("serve2");
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("go_state", 32'(st), 32'd4);
        chk("go_winner", 32'(win), 32'd2);
        chk("go_p2", 32'(s2), 32'd3);
        chk("go_brst", 32'(brst), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("go_hold_p1", 32'(s1), 32'd1);
        chk("go_hold_p2", 32'(s2), 32'd3);
        chk("go_hold_win", 32'(win), 32'd2);

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        wait_serve("serve3");
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pair_scores", 32'({s1, s2}), 32'd0);
        chk("pair_state", 32'(st), 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pause_state", 32'(st), 32'd3);
        chk("pause_en", 32'(en), 32'd0);
        idle();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_frozen", 32'(s1), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("resume_en", 32'(en), 32'd1);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        wait_serve("serve4");
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        wait_serve("serve5");
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        wait_serve("serve6");
        chk("pre_restart", 32'({s1, s2}), 32'h21);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("restart_scores", 32'({s1, s2}), 32'd0);
        chk("restart_state", 32'(st), 32'd1);
        chk("restart_win", 32'(win), 32'd0);

        @(negedge clk);
        start = 1'b0; p1 = 1'b0; p2 = 1'b0; pz = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_state", 32'(st), 32'd0);
        chk("midrst_outs", 32'({win, dir, en, brst}), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("post_rst_idle", 32'({st, brst}), 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(99) < 4,
                $urandom_range(99) < 20,
                $urandom_range(99) < 20,
                $urandom_range(99) < 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 9: score that ends the match (range 1..15).
REQ-002 SHALL have parameter SERVE_DELAY_CLKS, default 25000000: cycles from ball reset to ball release (1 s at 25 MHz, minimum 1).
REQ-003 SHALL have port i_Clk  in  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst_L  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_Start  in  1  one-cycle pulse that starts or restarts a match (UART byte received).
REQ-006 SHALL have port i_P1_Point  in  1  one-cycle pulse: ball passed P2 edge, so P1 scores.
REQ-007 SHALL have port i_P2_Point  in  1  one-cycle pulse: ball passed P1 edge, so P2 scores.
REQ-008 SHALL have port i_Pause  in  1  one-cycle pulse that toggles pause.
REQ-009 SHALL have port o_Ball_Enable  out  1  high only while ball motion is allowed.
REQ-010 SHALL have port o_Ball_Reset  out  1  one-cycle pulse that re-centres the ball.
REQ-011 SHALL have port o_Serve_Dir  out  1  serve direction: 0 = toward P1 (left), 1 = toward P2 (right).
REQ-012 SHALL have ports o_P1_Score and o_P2_Score  out  4 each  current scores.
REQ-013 SHALL have port o_Winner  out  2  00 none, 01 P1, 10 P2.
REQ-014 SHALL have port o_State  out  3  current state encoding, for debug.

Function
REQ-015 SHALL implement states IDLE, SERVE_WAIT, PLAY, PAUSED and GAME_OVER; all outputs are registered.
REQ-016 On i_Start in any state, SHALL clear both scores, set o_Winner=00, set o_Serve_Dir=0, pulse o_Ball_Reset, load the serve counter and enter SERVE_WAIT on the next edge.
REQ-017 In SERVE_WAIT, SHALL hold o_Ball_Enable=0 for exactly SERVE_DELAY_CLKS cycles, then enter PLAY.
REQ-018 In PLAY, SHALL drive o_Ball_Enable=1.
REQ-019 When a single point pulse arrives in PLAY, SHALL increment the scorer's score by 1 and update it one cycle after the pulse.
REQ-020 If the new score is below WIN_SCORE, SHALL pulse o_Ball_Reset, set o_Serve_Dir toward the player who conceded, reload the counter and enter SERVE_WAIT.
REQ-021 If the new score equals WIN_SCORE, SHALL enter GAME_OVER, set o_Winner to the scorer and issue no o_Ball_Reset.
REQ-022 SHALL ignore i_P1_Point and i_P2_Point asserted in the same cycle; no score change and no state change.
REQ-023 SHALL ignore point pulses in every state other than PLAY.
REQ-024 SHALL ignore i_Pause in all states except as follows: PLAY -> PAUSED and PAUSED -> PLAY.
REQ-025 In PAUSED, SHALL hold o_Ball_Enable=0 and freeze scores.
REQ-026 i_Start SHALL take priority over any point or pause pulse in the same cycle.
REQ-027 In GAME_OVER, SHALL hold scores and o_Winner until the next i_Start; o_Ball_Enable=0.
REQ-028 Scores SHALL never exceed WIN_SCORE; there is no wrap-around.
REQ-029 The serve counter width SHALL be $clog2(SERVE_DELAY_CLKS+1).

Reset
REQ-030 While i_Rst_L=0, SHALL immediately force state IDLE, scores 0, o_Winner=00, o_Serve_Dir=0, o_Ball_Enable=0, o_Ball_Reset=0 and serve counter 0.
REQ-031 Reset asserted mid-match SHALL abort the match with no residual o_Ball_Reset pulse after release; after release the block waits in IDLE for i_Start.

Structure
REQ-032 SHALL take the state encoding and the winner encoding (NONE/P1/P2) from the shared package pong_pkg.
REQ-033 SHALL place the serve delay counter in one sub-module, pong_serve_timer (inputs load and clock; output done pulse).
REQ-034 The RTL SHALL contain no VGA timing, drawing or debounce logic.

Verification (WIN_SCORE=3, SERVE_DELAY_CLKS=4)
REQ-035 Release reset, then pulse i_Start -> o_Ball_Reset high for 1 cycle, o_Ball_Enable=0 for exactly 4 cycles, then 1.
REQ-036 In PLAY, pulse i_P1_Point -> o_P1_Score=1, o_Serve_Dir=1, o_Ball_Reset pulse, enable low for 4 cycles.
REQ-037 Drive P2 to 3 points -> GAME_OVER, o_Winner=10, o_P2_Score=3, no reset pulse; further point pulses leave outputs unchanged.
REQ-038 Pulse i_P1_Point and i_P2_Point in the same cycle, then a pause pair -> scores unchanged; enable drops during PAUSED and resumes after.
REQ-039 Assert i_Rst_L=0 mid-SERVE_WAIT -> all outputs zero immediately; after release, state IDLE until i_Start.
REQ-040 Pulse i_Start and i_P1_Point in the same cycle during PLAY at score 2-1 -> scores 0-0, SERVE_WAIT, o_Winner=00.
